mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
MEM-stage load/store responder that consumes the request fields held by the EX/MEM pipeline register.
- Issues a valid/ready request to the Dcache and waits for the response.
- Drives the stall request that fc turns into fc_Dcache_stall_flag, which freezes the pipeline until the access completes.
- Aligns and extends load data; lane-replicates store data and generates byte strobes.
- Presents the writeback value, address and enable to the MEM/WB register.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32 because the lane logic assumes 4 bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_mem_reg_op_c_i  in  32  ALU result, used for the non-load writeback value
- ex_mem_reg_reg_waddr_i  in  5  destination register
- ex_mem_reg_reg_we_i  in  1  register write enable
- ex_mem_reg_mtype_i  in  1  1 = memory operation
- ex_mem_reg_mem_rw_i  in  1  0 = load, 1 = store
- ex_mem_reg_mem_width_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ex_mem_reg_mem_wr_data_i  in  32  store data, taken from the low bits
- ex_mem_reg_mem_rdtype_i  in  1  0 = sign-extend, 1 = zero-extend
- ex_mem_reg_mem_addr_i  in  32  byte address
- dc_req_valid_o  out  1  Dcache request valid
- dc_req_ready_i  in  1  Dcache accepts the request
- dc_req_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dc_req_we_o  out  1  write request
- dc_req_wstrb_o  out  4  byte strobes
- dc_req_wdata_o  out  32  lane-replicated store data
- dc_resp_valid_i  in  1  read data or write acknowledge
- dc_resp_rdata_i  in  32  read word
- mem_stall_o  out  1  stall request to fc
- mem_reg_wdata_o  out  32  writeback value
- mem_reg_waddr_o  out  5  writeback register (passthrough)
- mem_reg_we_o  out  1  writeback enable

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - If mtype=1, assert dc_req_valid_o in the same cycle.
  - ready=1 -> WAIT; ready=0 -> REQ.
  - If mtype=0, stay in IDLE with no request.
- REQ: hold dc_req_valid_o and all request fields stable until ready=1, then go to WAIT.
- WAIT: dc_req_valid_o=0. On dc_resp_valid_i=1:
  - for a load, capture the aligned/extended data into load_q;
  - go to DONE.
- DONE: no request. The EX/MEM register advances at the end of this cycle. Go to IDLE unconditionally; the still-held old request is never reissued.
- Response timing: the response arrives no earlier than the cycle after acceptance. A resp_valid seen in IDLE, REQ or DONE is ignored.
- Stall: mem_stall_o = (IDLE & mtype) | REQ | WAIT. It is 0 in DONE.
- Minimum latency: the stall is high for 2 cycles (accept in cycle 0, response in cycle 1, DONE in cycle 2 with the stall low).
- Back-to-back memory ops: IDLE, entered after DONE, sees the new op and launches it immediately.
- Store encoding:
  - byte: wdata={4{wd[7:0]}}, wstrb=4'b0001<<addr[1:0]
  - half: wdata={2{wd[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}
  - word: wdata=wd, wstrb=4'hF
- Loads: wstrb=0, we=0.
- Load extraction:
  - byte lane is selected by addr[1:0]; half lane by addr[1];
  - extension follows rdtype;
  - a word load takes the full rdata.
- Writeback value: mem_reg_wdata_o = (mtype & ~rw) ? load_q : op_c_i.
- Writeback enable: mem_reg_we_o = reg_we_i & ~mem_stall_o.
- Reset values:
  - load_q = 0;
  - all request outputs are 0, because the FSM is in IDLE and mtype is 0 after reset of the EX/MEM register;
  - mem_stall_o = 0.
- Reset mid-operation: return to IDLE asynchronously and drop any outstanding access. The Dcache shares rst_n.

Optional Feature:
MEM_LSU_MISALIGN_TRAP_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no Dcache request. The FSM goes IDLE->DONE directly, with the stall high for 1 cycle.
  - A new output, mem_misalign_o, is high in DONE for that access and is 0 at reset.
  - mem_reg_we_o is forced to 0 for that access.
- Undefined:
  - There is no mem_misalign_o port.
  - The low address bits are ignored for alignment: a half access uses addr[1], a word access uses the full word.

Decomposition:
- Package mem_lsu_pkg:
  - width encodings MEM_W_BYTE=2'b00, MEM_W_HALF=2'b01, MEM_W_WORD=2'b10;
  - FSM state localparams;
  - RW_LOAD / RW_STORE constants.
- One combinational sub-module, mem_load_align: rdata, addr[1:0], width and rdtype in; 32-bit extended value out. The store strobe/replication logic stays inline.

Test Plan:
- LB sign-extend: addr=0x1003, rdata=0x80_11_22_33, ready=1, response one cycle after acceptance -> stall high 2 cycles, wdata=0xFFFFFF80, we pulses once in DONE.
- LHU: addr=0x2002, rdata=0x9ABC_1234 -> wdata=0x00009ABC.
- SB: wr_data=0xDEADBEEF, addr=0x3001 -> dc_req_wdata_o=0xEFEFEFEF, wstrb=4'b0010, we=1. Then SW: addr=0x3004 -> wstrb=4'hF.
- Backpressure: ready low 3 cycles, response 2 cycles after acceptance -> valid and fields stable while ready low, stall high 6 cycles, exactly one request accepted.
- Back-to-back: LW 0x10 then SW 0x14 -> two requests, DONE between them, the held LW never reissued. Non-memory op -> no request, stall 0, wdata=op_c.
- Reset in WAIT: rst_n low for 1 cycle -> FSM returns to IDLE, stall 0, a late resp_valid is ignored.
- Misalign (macro defined): LW at 0x6 -> no request, mem_misalign_o=1 for 1 cycle, we=0.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings for the MEM-stage load/store unit.
// Width codes, load/store direction constants and FSM state type.
package mem_lsu_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half out of a 32-bit read word
// and sign- or zero-extends it. Word (and reserved width 11) passes through.
module mem_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_width,
  input  logic        i_rdtype,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection: byte by addr[1:0], half by addr[1]
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension: rdtype=1 zero-extends, rdtype=0 sign-extends
  always_comb begin
    o_data = i_rdata;
    case (i_width)
      MEM_W_BYTE: o_data = i_rdtype ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      MEM_W_HALF: o_data = i_rdtype ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default:    o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store responder between the EX/MEM register,
// the Dcache valid/ready request channel and the MEM/WB register.
// Optional macro MEM_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the Dcache, raise mem_misalign_o in DONE and suppress writeback.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ex_mem_reg_op_c_i,
  input  logic [4:0]    ex_mem_reg_reg_waddr_i,
  input  logic          ex_mem_reg_reg_we_i,
  input  logic          ex_mem_reg_mtype_i,
  input  logic          ex_mem_reg_mem_rw_i,
  input  logic [1:0]    ex_mem_reg_mem_width_i,
  input  logic [DW-1:0] ex_mem_reg_mem_wr_data_i,
  input  logic          ex_mem_reg_mem_rdtype_i,
  input  logic [AW-1:0] ex_mem_reg_mem_addr_i,
  output logic          dc_req_valid_o,
  input  logic          dc_req_ready_i,
  output logic [AW-1:0] dc_req_addr_o,
  output logic          dc_req_we_o,
  output logic [3:0]    dc_req_wstrb_o,
  output logic [DW-1:0] dc_req_wdata_o,
  input  logic          dc_resp_valid_i,
  input  logic [DW-1:0] dc_resp_rdata_i,
  output logic          mem_stall_o,
  output logic [DW-1:0] mem_reg_wdata_o,
  output logic [4:0]    mem_reg_waddr_o,
  output logic          mem_reg_we_o
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  ,
  output logic          mem_misalign_o
`endif
);

  lsu_state_e    r_state;
  lsu_state_e    w_next_state;
  logic          w_req_valid;
  logic          w_is_load;
  logic          w_stall;
  logic [3:0]    w_wstrb;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_load_aligned;
  logic [DW-1:0] r_load_q;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic w_misaligned;
  logic w_misalign_launch;
  logic r_misalign;

  assign w_misaligned =
    ((ex_mem_reg_mem_width_i == MEM_W_HALF) && ex_mem_reg_mem_addr_i[0]) ||
    ((ex_mem_reg_mem_width_i[1] == 1'b1) && (ex_mem_reg_mem_addr_i[1:0] != 2'b00));
`endif

  assign w_is_load = ex_mem_reg_mtype_i && (ex_mem_reg_mem_rw_i == RW_LOAD);

  mem_load_align u_load_align (
    .i_rdata   (dc_resp_rdata_i),
    .i_addr_lo (ex_mem_reg_mem_addr_i[1:0]),
    .i_width   (ex_mem_reg_mem_width_i),
    .i_rdtype  (ex_mem_reg_mem_rdtype_i),
    .o_data    (w_load_aligned)
  );

  // State register; reset drops any outstanding access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and request-valid decode
  always_comb begin
    w_next_state = r_state;
    w_req_valid  = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    w_misalign_launch = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (ex_mem_reg_mtype_i) begin
`ifdef MEM_LSU_MISALIGN_TRAP_EN
          if (w_misaligned) begin
            w_misalign_launch = 1'b1;
            w_next_state      = ST_DONE;
          end else begin
            w_req_valid  = 1'b1;
            w_next_state = dc_req_ready_i ? ST_WAIT : ST_REQ;
          end
`else
          w_req_valid  = 1'b1;
          w_next_state = dc_req_ready_i ? ST_WAIT : ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        w_req_valid = 1'b1;
        if (dc_req_ready_i) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (dc_resp_valid_i) w_next_state = ST_DONE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Load data capture on the response, only while waiting for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_q <= '0;
    end else if ((r_state == ST_WAIT) && dc_resp_valid_i &&
                 (ex_mem_reg_mem_rw_i == RW_LOAD)) begin
      r_load_q <= w_load_aligned;
    end
  end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  // Misalign flag lives exactly in the DONE cycle following the skipped access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_misalign_launch;
  end

  assign mem_misalign_o = r_misalign;
`endif

  // Store lane replication and byte strobes; loads carry no strobes or data
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = '0;
    if (ex_mem_reg_mem_rw_i == RW_STORE) begin
      case (ex_mem_reg_mem_width_i)
        MEM_W_BYTE: begin
          w_wdata = {4{ex_mem_reg_mem_wr_data_i[7:0]}};
          w_wstrb = 4'b0001 << ex_mem_reg_mem_addr_i[1:0];
        end
        MEM_W_HALF: begin
          w_wdata = {2{ex_mem_reg_mem_wr_data_i[15:0]}};
          w_wstrb = 4'b0011 << {ex_mem_reg_mem_addr_i[1], 1'b0};
        end
        default: begin
          w_wdata = ex_mem_reg_mem_wr_data_i;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign w_stall = ((r_state == ST_IDLE) && ex_mem_reg_mtype_i) ||
                   (r_state == ST_REQ) || (r_state == ST_WAIT);

  assign dc_req_valid_o = w_req_valid;
  assign dc_req_addr_o  = w_req_valid ? {ex_mem_reg_mem_addr_i[AW-1:2], 2'b00} : '0;
  assign dc_req_we_o    = w_req_valid && (ex_mem_reg_mem_rw_i == RW_STORE);
  assign dc_req_wstrb_o = w_req_valid ? w_wstrb : 4'b0000;
  assign dc_req_wdata_o = w_req_valid ? w_wdata : '0;

  assign mem_stall_o     = w_stall;
  assign mem_reg_wdata_o = w_is_load ? r_load_q : ex_mem_reg_op_c_i;
  assign mem_reg_waddr_o = ex_mem_reg_reg_waddr_i;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign mem_reg_we_o    = ex_mem_reg_reg_we_i && !w_stall && !r_misalign;
`else
  assign mem_reg_we_o    = ex_mem_reg_reg_we_i && !w_stall;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a small Dcache responder.
// Misalign tests are built only with MEM_LSU_MISALIGN_TRAP_EN defined.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] opC;
  logic [4:0]  regWaddr;
  logic        regWe;
  logic        mtype;
  logic        memRw;
  logic [1:0]  memWidth;
  logic [31:0] memWrData;
  logic        memRdtype;
  logic [31:0] memAddr;
  logic        dcReqValid;
  logic        dcReqReady;
  logic [31:0] dcReqAddr;
  logic        dcReqWe;
  logic [3:0]  dcReqWstrb;
  logic [31:0] dcReqWdata;
  logic        dcRespValid;
  logic [31:0] dcRespRdata;
  logic        memStall;
  logic [31:0] memRegWdata;
  logic [4:0]  memRegWaddr;
  logic        memRegWe;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic        memMisalign;
`endif

  int checks;
  int errors;

  int          obsStall;
  int          obsValidCycles;
  int          obsAccepted;
  int          obsWeCycles;
  int          obsUnstable;
  int          obsMisalign;
  logic        obsTimeout;
  logic        obsFirstValid;
  logic        obsDoneValid;
  logic [31:0] obsDoneWdata;
  logic [31:0] accAddr;
  logic        accWe;
  logic [3:0]  accWstrb;
  logic [31:0] accWdata;

  mem_lsu #(.AW(32), .DW(32)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ex_mem_reg_op_c_i        (opC),
    .ex_mem_reg_reg_waddr_i   (regWaddr),
    .ex_mem_reg_reg_we_i      (regWe),
    .ex_mem_reg_mtype_i       (mtype),
    .ex_mem_reg_mem_rw_i      (memRw),
    .ex_mem_reg_mem_width_i   (memWidth),
    .ex_mem_reg_mem_wr_data_i (memWrData),
    .ex_mem_reg_mem_rdtype_i  (memRdtype),
    .ex_mem_reg_mem_addr_i    (memAddr),
    .dc_req_valid_o           (dcReqValid),
    .dc_req_ready_i           (dcReqReady),
    .dc_req_addr_o            (dcReqAddr),
    .dc_req_we_o              (dcReqWe),
    .dc_req_wstrb_o           (dcReqWstrb),
    .dc_req_wdata_o           (dcReqWdata),
    .dc_resp_valid_i          (dcRespValid),
    .dc_resp_rdata_i          (dcRespRdata),
    .mem_stall_o              (memStall),
    .mem_reg_wdata_o          (memRegWdata),
    .mem_reg_waddr_o          (memRegWaddr),
    .mem_reg_we_o             (memRegWe)
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    ,
    .mem_misalign_o           (memMisalign)
`endif
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one EX/MEM op and play the Dcache until the LSU stops stalling.
  // The pipeline advances after the non-stalled cycle; caller drives the next op.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] width,
                               input logic rw, input logic rdtype,
                               input logic [31:0] wd, input logic [31:0] opc,
                               input logic we, input logic mt,
                               input logic [31:0] rdata,
                               input int readyDelay, input int respDelay);
    int   acceptCycle;
    logic haveFields;
    logic done;
    logic [31:0] fAddr;
    logic        fWe;
    logic [3:0]  fWstrb;
    logic [31:0] fWdata;
    acceptCycle    = 0;
    haveFields     = 1'b0;
    done           = 1'b0;
    fAddr = '0; fWe = 1'b0; fWstrb = '0; fWdata = '0;
    obsStall       = 0;
    obsValidCycles = 0;
    obsAccepted    = 0;
    obsWeCycles    = 0;
    obsUnstable    = 0;
    obsMisalign    = 0;
    obsTimeout     = 1'b0;
    obsFirstValid  = 1'b0;
    obsDoneValid   = 1'b0;
    obsDoneWdata   = '0;
    accAddr = '0; accWe = 1'b0; accWstrb = '0; accWdata = '0;
    @(negedge clk);
    memAddr   = addr;
    memWidth  = width;
    memRw     = rw;
    memRdtype = rdtype;
    memWrData = wd;
    opC       = opc;
    regWe     = we;
    regWaddr  = 5'd7;
    mtype     = mt;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      dcReqReady  = (c >= readyDelay) && (obsAccepted == 0);
      dcRespValid = (obsAccepted > 0) && (c == acceptCycle + respDelay);
      dcRespRdata = dcRespValid ? rdata : 32'h5A5A_A5A5;
      #1;
      if (c == 0) obsFirstValid = dcReqValid;
      if (dcReqValid) begin
        obsValidCycles++;
        if (!haveFields) begin
          fAddr = dcReqAddr; fWe = dcReqWe; fWstrb = dcReqWstrb; fWdata = dcReqWdata;
          haveFields = 1'b1;
        end else if ((fAddr !== dcReqAddr) || (fWe !== dcReqWe) ||
                     (fWstrb !== dcReqWstrb) || (fWdata !== dcReqWdata)) begin
          obsUnstable++;
        end
      end
      if (dcReqValid && dcReqReady) begin
        obsAccepted++;
        acceptCycle = c;
        accAddr = dcReqAddr; accWe = dcReqWe; accWstrb = dcReqWstrb; accWdata = dcReqWdata;
      end
      if (memStall) obsStall++;
      if (memRegWe) obsWeCycles++;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      if (memMisalign) obsMisalign++;
`endif
      if (!memStall) begin
        obsDoneValid = dcReqValid;
        obsDoneWdata = memRegWdata;
        done = 1'b1;
        break;
      end
    end
    if (!done) obsTimeout = 1'b1;
    dcReqReady  = 1'b0;
    dcRespValid = 1'b0;
  endtask

  // Let the pipeline go idle for one cycle
  task automatic idleCycle();
    @(negedge clk);
    mtype = 1'b0;
    regWe = 1'b0;
    dcReqReady  = 1'b0;
    dcRespValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opC = 32'hAAAA_5555; regWaddr = '0; regWe = 1'b0; mtype = 1'b0; memRw = 1'b0;
    memWidth = '0; memWrData = '0; memRdtype = 1'b0; memAddr = '0;
    dcReqReady = 1'b0; dcRespValid = 1'b0; dcRespRdata = '0;
    #2;
    checks++; if (memStall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b expected 0", memStall); end
    checks++; if (dcReqValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", dcReqValid); end
    checks++; if (dcReqWstrb !== 4'h0) begin errors++; $display("[TB] FAIL rst_wstrb: got %h expected 0", dcReqWstrb); end
    checks++; if (dcReqWe !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_we: got %b expected 0", dcReqWe); end
    checks++; if (dcReqAddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0", dcReqAddr); end
    checks++; if (memRegWdata !== 32'hAAAA_5555) begin errors++; $display("[TB] FAIL rst_wb_opc: got %h expected aaaa5555", memRegWdata); end
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    checks++; if (memMisalign !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign: got %b expected 0", memMisalign); end
`endif
    mtype = 1'b1;
    #1;
    checks++; if (memRegWdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_load_q: got %h expected 0", memRegWdata); end
    mtype = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_byte();
    applyStimulus(32'h1003, 2'b00, 1'b0, 1'b0, 32'h0, 32'h55, 1'b1, 1'b1, 32'h8011_2233, 0, 1);
    checks++; if (obsTimeout !== 1'b0) begin errors++; $display("[TB] FAIL lb_timeout: got %b expected 0", obsTimeout); end
    checks++; if (obsStall != 2) begin errors++; $display("[TB] FAIL lb_stall_cycles: got %0d expected 2", obsStall); end
    checks++; if (obsAccepted != 1) begin errors++; $display("[TB] FAIL lb_accepts: got %0d expected 1", obsAccepted); end
    checks++; if (obsDoneWdata !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_wdata: got %h expected ffffff80", obsDoneWdata); end
    checks++; if (obsWeCycles != 1) begin errors++; $display("[TB] FAIL lb_we_pulses: got %0d expected 1", obsWeCycles); end
    checks++; if (accAddr !== 32'h1000) begin errors++; $display("[TB] FAIL lb_req_addr: got %h expected 00001000", accAddr); end
    checks++; if ({accWe, accWstrb} !== 5'b0_0000) begin errors++; $display("[TB] FAIL lb_we_wstrb: got %b expected 00000", {accWe, accWstrb}); end
    applyStimulus(32'h1001, 2'b00, 1'b0, 1'b1, 32'h0, 32'h55, 1'b1, 1'b1, 32'h8011_2233, 0, 1);
    checks++; if (obsDoneWdata !== 32'h0000_0022) begin errors++; $display("[TB] FAIL lbu_wdata: got %h expected 00000022", obsDoneWdata); end
    idleCycle();
  endtask

  task automatic test_load_half();
    applyStimulus(32'h2002, 2'b01, 1'b0, 1'b1, 32'h0, 32'h66, 1'b1, 1'b1, 32'h9ABC_1234, 0, 1);
    checks++; if (obsDoneWdata !== 32'h0000_9ABC) begin errors++; $display("[TB] FAIL lhu_wdata: got %h expected 00009abc", obsDoneWdata); end
    applyStimulus(32'h2000, 2'b01, 1'b0, 1'b0, 32'h0, 32'h66, 1'b1, 1'b1, 32'h1234_8765, 0, 1);
    checks++; if (obsDoneWdata !== 32'hFFFF_8765) begin errors++; $display("[TB] FAIL lh_wdata: got %h expected ffff8765", obsDoneWdata); end
    idleCycle();
  endtask

  task automatic test_store();
    applyStimulus(32'h3001, 2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h3001, 1'b0, 1'b1, 32'h0, 0, 1);
    checks++; if (accWdata !== 32'hEFEF_EFEF) begin errors++; $display("[TB] FAIL sb_wdata: got %h expected efefefef", accWdata); end
    checks++; if (accWstrb !== 4'b0010) begin errors++; $display("[TB] FAIL sb_wstrb: got %b expected 0010", accWstrb); end
    checks++; if (accWe !== 1'b1) begin errors++; $display("[TB] FAIL sb_we: got %b expected 1", accWe); end
    checks++; if (accAddr !== 32'h3000) begin errors++; $display("[TB] FAIL sb_addr: got %h expected 00003000", accAddr); end
    checks++; if (obsDoneWdata !== 32'h3001) begin errors++; $display("[TB] FAIL sb_wb_opc: got %h expected 00003001", obsDoneWdata); end
    checks++; if (obsWeCycles != 0) begin errors++; $display("[TB] FAIL sb_wb_we: got %0d expected 0", obsWeCycles); end
    applyStimulus(32'h3002, 2'b01, 1'b1, 1'b0, 32'h1234_CAFE, 32'h0, 1'b0, 1'b1, 32'h0, 0, 1);
    checks++; if ({accWstrb, accWdata} !== {4'b1100, 32'hCAFE_CAFE}) begin errors++; $display("[TB] FAIL sh_strb_data: got %b %h expected 1100 cafecafe", accWstrb, accWdata); end
    applyStimulus(32'h3004, 2'b10, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 32'h0, 0, 1);
    checks++; if ({accWstrb, accWdata} !== {4'hF, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL sw_strb_data: got %h %h expected f deadbeef", accWstrb, accWdata); end
    checks++; if (accAddr !== 32'h3004) begin errors++; $display("[TB] FAIL sw_addr: got %h expected 00003004", accAddr); end
    idleCycle();
  endtask

  task automatic test_backpressure();
    applyStimulus(32'h4008, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 3, 2);
    checks++; if (obsTimeout !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout: got %b expected 0", obsTimeout); end
    checks++; if (obsStall != 6) begin errors++; $display("[TB] FAIL bp_stall_cycles: got %0d expected 6", obsStall); end
    checks++; if (obsAccepted != 1) begin errors++; $display("[TB] FAIL bp_accepts: got %0d expected 1", obsAccepted); end
    checks++; if (obsValidCycles != 4) begin errors++; $display("[TB] FAIL bp_valid_cycles: got %0d expected 4", obsValidCycles); end
    checks++; if (obsUnstable != 0) begin errors++; $display("[TB] FAIL bp_field_changes: got %0d expected 0", obsUnstable); end
    checks++; if (obsDoneWdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL bp_wdata: got %h expected cafef00d", obsDoneWdata); end
    checks++; if (obsWeCycles != 1) begin errors++; $display("[TB] FAIL bp_we_pulses: got %0d expected 1", obsWeCycles); end
    idleCycle();
  endtask

  task automatic test_back_to_back();
    int          firstValidCycles;
    int          firstAccepted;
    logic        firstDoneValid;
    logic [31:0] firstWdata;
    applyStimulus(32'h10, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1111_2222, 0, 1);
    firstValidCycles = obsValidCycles;
    firstAccepted    = obsAccepted;
    firstDoneValid   = obsDoneValid;
    firstWdata       = obsDoneWdata;
    applyStimulus(32'h14, 2'b10, 1'b1, 1'b0, 32'h3333_4444, 32'h0, 1'b0, 1'b1, 32'h0, 0, 1);
    checks++; if (firstAccepted != 1 || firstValidCycles != 1) begin errors++; $display("[TB] FAIL b2b_lw_requests: got %0d/%0d expected 1/1", firstAccepted, firstValidCycles); end
    checks++; if (firstDoneValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_lw_done_valid: got %b expected 0", firstDoneValid); end
    checks++; if (firstWdata !== 32'h1111_2222) begin errors++; $display("[TB] FAIL b2b_lw_wdata: got %h expected 11112222", firstWdata); end
    checks++; if (obsFirstValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sw_immediate: got %b expected 1", obsFirstValid); end
    checks++; if (obsAccepted != 1 || obsValidCycles != 1) begin errors++; $display("[TB] FAIL b2b_sw_requests: got %0d/%0d expected 1/1", obsAccepted, obsValidCycles); end
    checks++; if ({accAddr, accWe, accWstrb} !== {32'h14, 1'b1, 4'hF}) begin errors++; $display("[TB] FAIL b2b_sw_fields: got %h %b %h expected 00000014 1 f", accAddr, accWe, accWstrb); end
    applyStimulus(32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 0, 1);
    checks++; if (obsStall != 0 || obsValidCycles != 0) begin errors++; $display("[TB] FAIL alu_no_req: got stall %0d valid %0d expected 0 0", obsStall, obsValidCycles); end
    checks++; if (obsDoneWdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL alu_wdata: got %h expected 12345678", obsDoneWdata); end
    checks++; if (obsWeCycles != 1) begin errors++; $display("[TB] FAIL alu_we: got %0d expected 1", obsWeCycles); end
    checks++; if (memRegWaddr !== 5'd7) begin errors++; $display("[TB] FAIL alu_waddr: got %0d expected 7", memRegWaddr); end
    idleCycle();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    memAddr = 32'h5000; memWidth = 2'b10; memRw = 1'b0; memRdtype = 1'b0;
    regWe = 1'b1; mtype = 1'b1; dcReqReady = 1'b1; dcRespValid = 1'b0;
    @(negedge clk);
    dcReqReady = 1'b0;
    #1;
    checks++; if (memStall !== 1'b1 || dcReqValid !== 1'b0) begin errors++; $display("[TB] FAIL rw_in_wait: got stall %b valid %b expected 1 0", memStall, dcReqValid); end
    rst_n = 1'b0;
    mtype = 1'b0;
    #1;
    checks++; if (memStall !== 1'b0 || dcReqValid !== 1'b0) begin errors++; $display("[TB] FAIL rw_after_reset: got stall %b valid %b expected 0 0", memStall, dcReqValid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dcRespValid = 1'b1;
    dcRespRdata = 32'h7777_7777;
    #1;
    checks++; if (memStall !== 1'b0) begin errors++; $display("[TB] FAIL rw_late_resp_stall: got %b expected 0", memStall); end
    applyStimulus(32'h5000, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0102_0304, 0, 1);
    checks++; if (obsFirstValid !== 1'b1) begin errors++; $display("[TB] FAIL rw_idle_relaunch: got %b expected 1", obsFirstValid); end
    checks++; if (obsStall != 2 || obsDoneWdata !== 32'h0102_0304) begin errors++; $display("[TB] FAIL rw_new_load: got %0d %h expected 2 01020304", obsStall, obsDoneWdata); end
    idleCycle();
  endtask

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    applyStimulus(32'h6, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 1);
    checks++; if (obsValidCycles != 0 || obsAccepted != 0) begin errors++; $display("[TB] FAIL mis_no_req: got %0d/%0d expected 0/0", obsValidCycles, obsAccepted); end
    checks++; if (obsStall != 1) begin errors++; $display("[TB] FAIL mis_stall: got %0d expected 1", obsStall); end
    checks++; if (obsMisalign != 1) begin errors++; $display("[TB] FAIL mis_flag: got %0d expected 1", obsMisalign); end
    checks++; if (obsWeCycles != 0) begin errors++; $display("[TB] FAIL mis_we: got %0d expected 0", obsWeCycles); end
    idleCycle();
    #1;
    checks++; if (memMisalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_flag_clear: got %b expected 0", memMisalign); end
  endtask
`endif

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
